// File: rtl/sa_ctrl_pkg.sv
// rtl/sa_ctrl_pkg.sv - shared state encoding and sizing helpers for the systolic-array sequencer
package sa_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CLEAR,
        ST_FEED,
        ST_FLUSH,
        ST_DRAIN,
        ST_DONE
    } sa_state_e;

    function automatic int sa_clog2(input int v);
        int r;
        for (r = 0; (1 << r) < v; r++) begin
        end
        return r;
    endfunction

    // Last operand reaches the far corner PE after ROWS-1 + COLS-1 hops, then the PE pipeline.
    function automatic int flush_cycles(input int rows, input int cols, input int pe_lat);
        return rows + cols - 2 + pe_lat;
    endfunction

    localparam int ROWS_DEF   = 4;
    localparam int COLS_DEF   = 4;
    localparam int PE_LAT_DEF = 2;
    localparam int FLUSH_CYC  = flush_cycles(ROWS_DEF, COLS_DEF, PE_LAT_DEF);

endpackage

// File: rtl/sa_skew_line.sv
// rtl/sa_skew_line.sv - valid delay line; tap i is din delayed i cycles, tap 0 is din itself
module sa_skew_line #(
    parameter int DEPTH = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             din,
    output logic [DEPTH:0]   vld
);

    logic [DEPTH-1:0] sr;

    assign vld = {sr, din};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sr <= '0;
        end else if (clr) begin
            sr <= '0;
        end else begin
            sr <= vld[DEPTH-1:0];
        end
    end

endmodule

// File: rtl/sa_os_seq_ctrl.sv
// rtl/sa_os_seq_ctrl.sv - job sequencer for an output-stationary Booth systolic array
module sa_os_seq_ctrl
    import sa_ctrl_pkg::*;
#(
    parameter int ROWS   = 4,
    parameter int COLS   = 4,
    parameter int PE_LAT = 2,
    parameter int KW     = 8
) (
    input  logic                      CLK,
    input  logic                      RST,
    input  logic                      start,
    input  logic [KW-1:0]             k_len,
    input  logic                      abort,
    output logic                      start_ack,
    output logic                      start_err,
    output logic                      busy,
    output logic                      acc_clr,
    output logic                      rd_en,
    output logic [KW-1:0]             k_idx,
    output logic [ROWS-1:0]           a_vld,
    output logic [COLS-1:0]           b_vld,
    output logic [sa_clog2(ROWS)-1:0] row_sel,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic                      done
);

    localparam int FL  = flush_cycles(ROWS, COLS, PE_LAT);
    localparam int FCW = sa_clog2(ROWS + COLS + PE_LAT);
    localparam int RSW = sa_clog2(ROWS);
    localparam logic [FCW-1:0] FL_LAST  = FCW'(FL - 1);
    localparam logic [RSW-1:0] ROW_LAST = RSW'(ROWS - 1);

    sa_state_e      state, state_nxt;
    logic [KW-1:0]  klen_q;
    logic [FCW-1:0] flush_cnt;
    logic           k_last;
    logic           abort_job;
    logic           accept;
    logic           reject;

    // Comparing against k_len-1 keeps k_len = 2^KW-1 from wrapping the counter early.
    assign k_last    = (k_idx == klen_q - KW'(1));
    assign abort_job = abort && (state != ST_IDLE);
    assign accept    = (state == ST_IDLE) && start && !abort && (k_len != '0);
    assign reject    = (state == ST_IDLE) && start && !abort && (k_len == '0);

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) state <= ST_IDLE;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (abort_job) begin
            state_nxt = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE:  if (accept) state_nxt = ST_CLEAR;
                ST_CLEAR: state_nxt = ST_FEED;
                ST_FEED:  if (k_last) state_nxt = ST_FLUSH;
                ST_FLUSH: if (flush_cnt == FL_LAST) state_nxt = ST_DRAIN;
                ST_DRAIN: if (out_ready && row_sel == ROW_LAST) state_nxt = ST_DONE;
                ST_DONE:  state_nxt = ST_IDLE;
                default:  state_nxt = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        busy      = (state != ST_IDLE);
        acc_clr   = (state == ST_CLEAR);
        rd_en     = (state == ST_FEED);
        out_valid = (state == ST_DRAIN);
        done      = (state == ST_DONE);
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            start_ack <= 1'b0;
            start_err <= 1'b0;
            klen_q    <= '0;
            k_idx     <= '0;
            flush_cnt <= '0;
            row_sel   <= '0;
        end else begin
            start_ack <= accept;
            start_err <= reject;
            if (accept) klen_q <= k_len;
            if (abort_job) begin
                k_idx     <= '0;
                flush_cnt <= '0;
                row_sel   <= '0;
            end else begin
                case (state)
                    ST_FEED:  k_idx <= k_last ? '0 : k_idx + KW'(1);
                    ST_FLUSH: flush_cnt <= (flush_cnt == FL_LAST) ? '0 : flush_cnt + FCW'(1);
                    ST_DRAIN: if (out_ready) row_sel <= (row_sel == ROW_LAST) ? '0 : row_sel + RSW'(1);
                    default:  ;
                endcase
            end
        end
    end

    sa_skew_line #(.DEPTH(ROWS - 1)) u_a_skew (
        .clk   (CLK),
        .rst_n (RST),
        .clr   (abort_job),
        .din   (rd_en),
        .vld   (a_vld)
    );

    sa_skew_line #(.DEPTH(COLS - 1)) u_b_skew (
        .clk   (CLK),
        .rst_n (RST),
        .clr   (abort_job),
        .din   (rd_en),
        .vld   (b_vld)
    );

endmodule

// File: doc/sa_os_seq_ctrl.md
Name: sa_os_seq_ctrl

Overview:
- Sequencer for an R×C output-stationary radix-8 Booth systolic array built from PE_OS_16_R8 tiles.
- Accepts a job of K accumulation steps and clears the PE accumulators.
- Generates row- and column-skewed operand-valid strobes and operand-buffer read addresses, waits for the wavefront to flush, then drains MAC results row by row over a valid/ready handshake.
- Sits between the job front-end and the array plus its operand SRAMs.

Parameters:
- ROWS, 4, array rows (≥2).
- COLS, 4, array columns (≥2).
- PE_LAT, 2, cycles from operand entry into a PE until its MAC_OUT includes that product.
- KW, 8, width of the K-length field.

Ports:
- CLK  in  1  clock, rising edge.
- RST  in  1  asynchronous active-low reset.
- start  in  1  job request, sampled only in IDLE.
- k_len  in  KW  accumulation depth; sampled with start.
- abort  in  1  synchronous abort; highest priority after reset.
- start_ack  out  1  one-cycle pulse when a job is accepted.
- start_err  out  1  one-cycle pulse when start arrives with k_len==0.
- busy  out  1  high in every state except IDLE.
- acc_clr  out  1  synchronous accumulator clear to all PEs.
- rd_en  out  1  operand-buffer read enable (unskewed).
- k_idx  out  KW  operand-buffer read address.
- a_vld  out  ROWS  row-skewed operand valid; bit i is rd_en delayed i cycles.
- b_vld  out  COLS  column-skewed operand valid; bit j is rd_en delayed j cycles.
- row_sel  out  clog2(ROWS)  MAC_OUT row mux select during drain.
- out_valid  out  1  result row valid.
- out_ready  in  1  downstream accepts the row.
- done  out  1  one-cycle pulse at job completion.

Behaviour:
- Reset (RST low, asynchronous): state=IDLE. All outputs 0, including the skew shift registers, k_idx and row_sel.
- States: IDLE, CLEAR, FEED, FLUSH, DRAIN, DONE. Cycle numbers below count from the edge that samples start (cycle 0).
- IDLE, start=1, k_len≠0:
  - Latch k_len, pulse start_ack (registered, cycle 1).
  - Next state CLEAR.
- IDLE, start=1, k_len==0: pulse start_err in cycle 1; remain IDLE.
- CLEAR (1 cycle, cycle 1): acc_clr=1. Next state FEED.
- FEED (k_len cycles):
  - rd_en=1; k_idx counts 0..k_len-1, one per cycle.
  - On the last count go to FLUSH; k_idx returns to 0.
  - For k_len=2^KW−1 the counter must not wrap early; compare against k_len−1.
- a_vld/b_vld: shift registers of depth ROWS−1 / COLS−1 fed from rd_en. Bit 0 is combinationally equal to rd_en. They keep shifting in FLUSH.
- FLUSH: fixed ROWS+COLS−2+PE_LAT cycles.
  - Counts from the first cycle after FEED, covering the last operand reaching PE[ROWS−1][COLS−1] plus PE latency.
  - Then go to DRAIN with row_sel=0.
- DRAIN:
  - out_valid=1 with row_sel=r.
  - On out_valid&out_ready: r increments.
  - On transfer of row ROWS−1: go to DONE.
  - row_sel holds while out_ready=0; there is no timeout.
- DONE (1 cycle): done=1, busy=1. Next state IDLE; start is not sampled in DONE.
- busy: 1 from the cycle after acceptance through the DONE cycle inclusive.
- abort=1 in any non-IDLE state:
  - Next cycle IDLE, with rd_en, a_vld, b_vld, out_valid and acc_clr forced 0.
  - Shift registers clear; no done pulse.
  - abort in IDLE is ignored; abort beats start in the same cycle.
- Reset mid-job: outputs drop immediately (async); no done pulse.
- Counter width: FLUSH counter is clog2(ROWS+COLS+PE_LAT).

Decomposition:
- Shared package sa_ctrl_pkg:
  - State enum.
  - FLUSH_CYC = ROWS+COLS−2+PE_LAT.
  - clog2 helper.
- One sub-module, sa_skew_line: parameterised-depth valid delay line with async active-low clear and sync clear. Instantiated twice, for a_vld and b_vld.

Test Plan (ROWS=COLS=4, PE_LAT=2, KW=8):
- start, k_len=3, out_ready=1:
  - start_ack in cycle 1 and acc_clr in cycle 1 only.
  - rd_en cycles 2–4 with k_idx 0,1,2.
  - a_vld[3] high cycles 5–7.
  - FLUSH cycles 5–12.
  - out_valid cycles 13–16 with row_sel 0..3.
  - done in cycle 17; busy in cycles 1–17.
- Same job with out_ready low for 3 cycles at row 1: row_sel holds at 1 for 4 cycles; done is delayed exactly 3 cycles to cycle 20.
- start with k_len=0: start_err pulses once; busy, acc_clr and rd_en stay 0; no done.
- k_len=255: exactly 255 rd_en cycles, k_idx ends at 254 and returns to 0; done at cycle 269.
- abort during FEED at cycle 3: cycle 4 shows state IDLE, busy=0, all valids 0, no done. A new start immediately afterwards runs normally.
- RST asserted during DRAIN: out_valid and busy go to 0 without waiting for a clock edge. After release the block is IDLE and a fresh job reproduces the first scenario's timeline.
